// File: rtl/mips_avalon_master.sv
// Avalon-MM master bus interface for the MIPS core: turns one CPU load/store
// into a single Avalon transfer with lane steering, alignment checks and a wait timeout.
module mips_avalon_master #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] cnt_q, cnt_d;

    logic        req_legal;
    logic [3:0]  be_steer;
    logic [31:0] wd_steer;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;

    always_comb begin
        req_legal = 1'b1;
        if (req_size == 2'd3)                           req_legal = 1'b0;
        if (req_size == 2'd1 && req_addr[0])            req_legal = 1'b0;
        if (req_size == 2'd2 && req_addr[1:0] != 2'b00) req_legal = 1'b0;
    end

    // Little-endian lanes; narrow stores are replicated so any lane carries the data.
    always_comb begin
        be_steer = 4'b1111;
        wd_steer = req_wdata;
        case (req_size)
            2'd0: begin
                be_steer = 4'b0001 << req_addr[1:0];
                wd_steer = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be_steer = 4'b0011 << req_addr[1:0];
                wd_steer = {2{req_wdata[15:0]}};
            end
            default: begin
                be_steer = 4'b1111;
                wd_steer = req_wdata;
            end
        endcase
    end

    always_comb begin
        rd_shifted = readdata >> {offset_q, 3'b000};
        case (size_q)
            2'd0:    load_data = {24'd0, rd_shifted[7:0]};
            2'd1:    load_data = {16'd0, rd_shifted[15:0]};
            default: load_data = readdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        read_d       = read_q;
        write_d      = write_q;
        resp_valid_d = resp_valid_q;
        resp_error_d = resp_error_q;
        resp_rdata_d = resp_rdata_q;
        size_d       = size_q;
        offset_d     = offset_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        state_d      = BUS;
                        address_d    = {req_addr[31:2], 2'b00};
                        byteenable_d = be_steer;
                        writedata_d  = req_write ? wd_steer : '0;
                        read_d       = ~req_write;
                        write_d      = req_write;
                        size_d       = req_size;
                        offset_d     = req_addr[1:0];
                        cnt_d        = '0;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    state_d      = RESP;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = read_q ? load_data : '0;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
                    state_d      = RESP;
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                resp_error_d = 1'b0;
                resp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            size_q       <= '0;
            offset_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            read_q       <= read_d;
            write_q      <= write_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_avalon_master.sv
// Directed bench for mips_avalon_master: loads, stores, lane steering, errors,
// timeout and reset during a stalled transfer.
module tb_mips_avalon_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mips_avalon_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge; returns just after the accept edge.
    task automatic drive_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                             input logic [31:0] wd);
        req_write = w; req_addr = a; req_size = s; req_wdata = wd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; waitrequest = 1'b0; readdata = 32'h0;
        req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_wdata = '0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (read !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b exp 0", read); end
            n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b exp 0", write); end
            n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
            n_checks++; if (address !== 32'h0) begin n_fail++; $display("FAIL rst_address: got %h exp 0", address); end
        end
        req_valid = 1'b0;
        reset = 1'b0;
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
        n_checks++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL rst_no_bus: got r=%b w=%b exp 0/0", read, write); end
    endtask

    task automatic test_word_load();
        waitrequest = 1'b0; readdata = 32'hDEADBEEF;
        drive_req(1'b0, 32'h0000_0010, 2'd2, 32'h0);
        n_checks++; if (read !== 1'b1 || write !== 1'b0) begin n_fail++; $display("FAIL wl_strobe: got r=%b w=%b exp 1/0", read, write); end
        n_checks++; if (address !== 32'h10) begin n_fail++; $display("FAIL wl_address: got %h exp 00000010", address); end
        n_checks++; if (byteenable !== 4'hF) begin n_fail++; $display("FAIL wl_be: got %h exp f", byteenable); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wl_ready_busy: got %b exp 0", req_ready); end
        tick();
        n_checks++; if (read !== 1'b0) begin n_fail++; $display("FAIL wl_read_drop: got %b exp 0", read); end
        n_checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin n_fail++; $display("FAIL wl_resp: got v=%b e=%b exp 1/0", resp_valid, resp_error); end
        n_checks++; if (resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wl_rdata: got %h exp deadbeef", resp_rdata); end
        tick();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL wl_idle: got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_byte_store_waits();
        waitrequest = 1'b1; readdata = 32'h5555_5555;
        drive_req(1'b1, 32'h0000_0023, 2'd0, 32'h0000_00AB);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (write !== 1'b1 || read !== 1'b0) begin n_fail++; $display("FAIL bs_strobe[%0d]: got r=%b w=%b exp 0/1", i, read, write); end
            n_checks++; if (address !== 32'h20) begin n_fail++; $display("FAIL bs_address[%0d]: got %h exp 00000020", i, address); end
            n_checks++; if (byteenable !== 4'b1000) begin n_fail++; $display("FAIL bs_be[%0d]: got %b exp 1000", i, byteenable); end
            n_checks++; if (writedata !== 32'hABABABAB) begin n_fail++; $display("FAIL bs_wdata[%0d]: got %h exp abababab", i, writedata); end
            n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bs_early_resp[%0d]: got %b exp 0", i, resp_valid); end
            if (i == 2) waitrequest = 1'b0;
            tick();
        end
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL bs_write_drop: got %b exp 0", write); end
        n_checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b0) begin n_fail++; $display("FAIL bs_resp: got v=%b e=%b exp 1/0", resp_valid, resp_error); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL bs_rdata: got %h exp 0", resp_rdata); end
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bs_pulse: got %b exp 0", resp_valid); end
    endtask

    task automatic test_half_load();
        waitrequest = 1'b0; readdata = 32'h1234ABCD;
        drive_req(1'b0, 32'h0000_0006, 2'd1, 32'h0);
        n_checks++; if (address !== 32'h4) begin n_fail++; $display("FAIL hl_address: got %h exp 00000004", address); end
        n_checks++; if (byteenable !== 4'b1100) begin n_fail++; $display("FAIL hl_be: got %b exp 1100", byteenable); end
        tick();
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL hl_resp_valid: got %b exp 1", resp_valid); end
        n_checks++; if (resp_rdata !== 32'h00001234) begin n_fail++; $display("FAIL hl_rdata: got %h exp 00001234", resp_rdata); end
        tick();
    endtask

    // Byte load followed immediately by a half store once req_ready returns.
    task automatic test_back_to_back();
        waitrequest = 1'b0; readdata = 32'h1234ABCD;
        drive_req(1'b0, 32'h0000_0101, 2'd0, 32'h0);
        n_checks++; if (byteenable !== 4'b0010) begin n_fail++; $display("FAIL bb_be0: got %b exp 0010", byteenable); end
        tick();
        n_checks++; if (resp_rdata !== 32'h000000AB) begin n_fail++; $display("FAIL bb_rdata0: got %h exp 000000ab", resp_rdata); end
        tick();
        drive_req(1'b1, 32'h0000_0202, 2'd1, 32'hFFFF_5678);
        n_checks++; if (address !== 32'h200) begin n_fail++; $display("FAIL bb_address1: got %h exp 00000200", address); end
        n_checks++; if (byteenable !== 4'b1100) begin n_fail++; $display("FAIL bb_be1: got %b exp 1100", byteenable); end
        n_checks++; if (writedata !== 32'h56785678) begin n_fail++; $display("FAIL bb_wdata1: got %h exp 56785678", writedata); end
        tick();
        n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL bb_resp1: got v=%b d=%h exp 1/0", resp_valid, resp_rdata); end
        tick();
    endtask

    task automatic test_illegal();
        waitrequest = 1'b0; readdata = 32'hFFFF_FFFF;
        drive_req(1'b0, 32'h0000_0002, 2'd2, 32'h0);
        n_checks++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL mis_no_bus: got r=%b w=%b exp 0/0", read, write); end
        n_checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b1) begin n_fail++; $display("FAIL mis_resp: got v=%b e=%b exp 1/1", resp_valid, resp_error); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h exp 0", resp_rdata); end
        tick();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mis_idle: got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
        drive_req(1'b1, 32'h0000_0000, 2'd3, 32'h1);
        n_checks++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL sz3_no_bus: got r=%b w=%b exp 0/0", read, write); end
        n_checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b1) begin n_fail++; $display("FAIL sz3_resp: got v=%b e=%b exp 1/1", resp_valid, resp_error); end
        tick();
        drive_req(1'b0, 32'h0000_0001, 2'd1, 32'h0);
        n_checks++; if (read !== 1'b0 || resp_error !== 1'b1) begin n_fail++; $display("FAIL hodd_err: got r=%b e=%b exp 0/1", read, resp_error); end
        tick();
    endtask

    task automatic test_timeout();
        int unsigned n;
        waitrequest = 1'b1; readdata = 32'hCAFE_F00D;
        drive_req(1'b0, 32'h0000_0040, 2'd2, 32'h0);
        n = 0;
        while (read === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL to_strobe_len: got %0d exp 4", n); end
        n_checks++; if (resp_valid !== 1'b1 || resp_error !== 1'b1) begin n_fail++; $display("FAIL to_resp: got v=%b e=%b exp 1/1", resp_valid, resp_error); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h exp 0", resp_rdata); end
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL to_idle: got %b exp 1", req_ready); end

        drive_req(1'b0, 32'h0000_0044, 2'd2, 32'h0);
        tick();
        n_checks++; if (read !== 1'b1) begin n_fail++; $display("FAIL mr_read_before: got %b exp 1", read); end
        reset = 1'b1;
        tick();
        n_checks++; if (read !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL mr_drop: got r=%b v=%b exp 0/0", read, resp_valid); end
        n_checks++; if (address !== 32'h0 || byteenable !== 4'h0) begin n_fail++; $display("FAIL mr_clear: got a=%h be=%h exp 0/0", address, byteenable); end
        reset = 1'b0; waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (resp_valid !== 1'b0 || read !== 1'b0) begin n_fail++; $display("FAIL mr_quiet[%0d]: got v=%b r=%b exp 0/0", i, resp_valid, read); end
        end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mr_ready: got %b exp 1", req_ready); end
    endtask

    initial begin
        req_valid = 1'b0;
        test_reset();
        test_word_load();
        test_byte_store_waits();
        test_half_load();
        test_back_to_back();
        test_illegal();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
